// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl
// Resolves control-transfer instructions sitting in EX (taken branches, JAL,
// JALR). It computes the target and link address, then issues a registered,
// stall-aware PC redirect together with a flush of the three younger pipeline
// registers. It also keeps a saturating count of completed redirects.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no redirect pending; EX instruction is evaluated each cycle
// REDIRECT | redirect + flushes asserted; held while the pipeline is frozen

module branch_redirect_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid_i,
  input  logic [6:0]       ex_opcode_i,
  input  logic             ex_br_cond_i,
  input  logic [31:0]      ex_pc_i,
  input  logic [31:0]      ex_imm_i,
  input  logic [31:0]      ex_rs1_i,
  input  logic             stall_in_i,
  output logic             pc_redirect_o,
  output logic [31:0]      pc_target_o,
  output logic [31:0]      link_addr_o,
  output logic             flush_if_id_o,
  output logic             flush_id_ex_o,
  output logic             flush_ex_mem_o,
  output logic             misalign_err_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] redirect_cnt_o
);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic {
    IDLE     = 1'b0,
    REDIRECT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      target_q, target_d;
  logic [31:0]      link_q, link_d;
  logic             misalign_q, misalign_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             is_req;
  logic [31:0]      target_calc;
  logic             target_aligned;

  // Decode the EX opcode and compute the candidate target address
  always_comb begin
    is_req      = 1'b0;
    target_calc = ex_pc_i + ex_imm_i;
    case (ex_opcode_i)
      OP_BRANCH: is_req = ex_br_cond_i;
      OP_JAL:    is_req = 1'b1;
      OP_JALR: begin
        is_req      = 1'b1;
        target_calc = (ex_rs1_i + ex_imm_i) & 32'hFFFF_FFFE;
      end
      default:   is_req = 1'b0;
    endcase
  end

  // JALR already clears bit 0, so only bit 1 can flag a misaligned JALR target
  assign target_aligned = (target_calc[1:0] == 2'b00);

  // Next-state, request acceptance and redirect counting
  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    link_d     = link_q;
    misalign_d = 1'b0;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        if (ex_valid_i && !stall_in_i && is_req) begin
          target_d = target_calc;
          link_d   = ex_pc_i + 32'd4;
          if (target_aligned) begin
            state_d = REDIRECT;
          end else begin
            misalign_d = 1'b1;
          end
        end
      end
      REDIRECT: begin
        // EX holds a wrong-path instruction here, so its inputs are ignored
        if (!stall_in_i) begin
          state_d = IDLE;
          if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any pending redirect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      target_q   <= 32'd0;
      link_q     <= 32'd0;
      misalign_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      link_q     <= link_d;
      misalign_q <= misalign_d;
      cnt_q      <= cnt_d;
    end
  end

  // The single-bit state register drives the control outputs directly
  assign pc_redirect_o  = (state_q == REDIRECT);
  assign flush_if_id_o  = (state_q == REDIRECT);
  assign flush_id_ex_o  = (state_q == REDIRECT);
  assign flush_ex_mem_o = (state_q == REDIRECT);
  assign busy_o         = (state_q == REDIRECT);
  assign misalign_err_o = misalign_q;
  assign pc_target_o    = target_q;
  assign link_addr_o    = link_q;
  assign redirect_cnt_o = cnt_q;

endmodule
